// File: rtl/udma_spis_seq_if.sv
// Descriptor push port and rx/tx byte streams of the SPI-slave sequencer.
interface udma_spis_seq_if #(
  parameter int CNTW = 16
);
  logic            desc_valid;
  logic            desc_ready;
  logic [CNTW-1:0] desc_rxcnt;
  logic [CNTW-1:0] desc_dmcnt;
  logic [CNTW-1:0] desc_txcnt;

  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            rx_ready;

  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;

  modport slave (
    input  desc_valid, desc_rxcnt, desc_dmcnt, desc_txcnt,
    output desc_ready,
    output rx_valid, rx_data,
    input  rx_ready,
    input  tx_valid, tx_data,
    output tx_ready
  );

  modport master (
    output desc_valid, desc_rxcnt, desc_dmcnt, desc_txcnt,
    input  desc_ready,
    input  rx_valid, rx_data,
    output rx_ready,
    output tx_valid, tx_data,
    input  tx_ready
  );
endinterface

// File: rtl/udma_spis_seq.sv
// Descriptor queue plus frame sequencer feeding the SPI-slave engine; bridges
// engine rx/tx pulses to streams and retires each frame with a status record.
module udma_spis_seq #(
  parameter int DESC_DEPTH = 2,
  parameter int CNTW       = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            cfg_abort,
  udma_spis_seq_if.slave  bus,
  output logic [CNTW-1:0] cfgrxcnt,
  output logic [CNTW-1:0] cfgdmcnt,
  output logic [CNTW-1:0] cfgtxcnt,
  input  logic            seot,
  input  logic [7:0]      eng_rx_data,
  input  logic            eng_rx_wr,
  output logic [7:0]      eng_tx_data,
  input  logic            eng_tx_rd,
  output logic            busy,
  output logic            evt_done,
  output logic [CNTW-1:0] st_rxbytes,
  output logic [CNTW-1:0] st_txbytes,
  output logic [3:0]      st_flags
);

  localparam int AW = $clog2(DESC_DEPTH);

  typedef struct packed {
    logic [CNTW-1:0] rx;
    logic [CNTW-1:0] dm;
    logic [CNTW-1:0] tx;
  } desc_t;

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DONE} state_t;

  state_t state, state_n;

  desc_t         mem [DESC_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  desc_t         act;

  logic [CNTW-1:0] rx_cnt, tx_cnt;
  logic            ovf_f, udr_f, unarmed_f;
  logic            frame_end, retire;

  logic [7:0]      rx_hold;
  logic            rx_vld;
  logic [7:0]      stg_data;
  logic            stg_vld;
  logic            tx_fire;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = bus.desc_valid && !full && !cfg_abort;

  assign bus.desc_ready = !full;
  assign busy           = (state != IDLE);

  // NOTE: queue storage has no reset; pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{rx: bus.desc_rxcnt, dm: bus.desc_dmcnt, tx: bus.desc_txcnt};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (cfg_abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (seot) begin
          state_n = DONE;
        end else if (!empty) begin
          pop     = 1'b1;
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (seot)                        state_n = DONE;
        else if (eng_rx_wr || eng_tx_rd) state_n = ACTIVE;
      end
      ACTIVE: begin
        if (seot) state_n = DONE;
      end
      DONE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = ARMED;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (cfg_abort) begin
      state_n = IDLE;
      pop     = 1'b0;
    end
  end

  // Active descriptor doubles as the cfg* outputs, so they only move on pop or return to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        act <= '0;
    else if (cfg_abort)                 act <= '0;
    else if (pop)                       act <= mem[rd_ptr[AW-1:0]];
    else if (state == DONE)             act <= '0;
  end

  assign cfgrxcnt = act.rx;
  assign cfgdmcnt = act.dm;
  assign cfgtxcnt = act.tx;

  assign frame_end = cfg_abort || (state == DONE);
  assign retire    = (state == DONE) || (cfg_abort && state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_cnt    <= '0;
      tx_cnt    <= '0;
      ovf_f     <= 1'b0;
      udr_f     <= 1'b0;
      unarmed_f <= 1'b0;
    end else if (frame_end) begin
      rx_cnt    <= '0;
      tx_cnt    <= '0;
      ovf_f     <= 1'b0;
      udr_f     <= 1'b0;
      unarmed_f <= 1'b0;
    end else begin
      if (eng_rx_wr && rx_cnt != '1) rx_cnt <= rx_cnt + CNTW'(1);
      if (eng_tx_rd && tx_cnt != '1) tx_cnt <= tx_cnt + CNTW'(1);
      if (eng_rx_wr && rx_vld && !bus.rx_ready) ovf_f <= 1'b1;
      if (eng_tx_rd && !stg_vld)                udr_f <= 1'b1;
      if (state == IDLE && seot)                unarmed_f <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      evt_done   <= 1'b0;
      st_rxbytes <= '0;
      st_txbytes <= '0;
      st_flags   <= '0;
    end else begin
      evt_done <= retire;
      if (retire) begin
        st_rxbytes <= rx_cnt;
        st_txbytes <= tx_cnt;
        st_flags   <= {unarmed_f, cfg_abort || (rx_cnt < act.rx), udr_f, ovf_f};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_vld  <= 1'b0;
      rx_hold <= '0;
    end else if (cfg_abort) begin
      rx_vld  <= 1'b0;
    end else if (eng_rx_wr) begin
      rx_vld  <= 1'b1;
      rx_hold <= eng_rx_data;
    end else if (rx_vld && bus.rx_ready) begin
      rx_vld  <= 1'b0;
    end
  end

  assign bus.rx_valid = rx_vld;
  assign bus.rx_data  = rx_hold;

  assign bus.tx_ready = !stg_vld || eng_tx_rd;
  assign tx_fire      = bus.tx_valid && bus.tx_ready;
  assign eng_tx_data  = stg_vld ? stg_data : 8'hFF;

  // A byte accepted during DONE belongs to the next frame; anything older is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stg_vld  <= 1'b0;
      stg_data <= '0;
    end else if (cfg_abort) begin
      stg_vld  <= 1'b0;
    end else if (tx_fire) begin
      stg_vld  <= 1'b1;
      stg_data <= bus.tx_data;
    end else if (eng_tx_rd || state == DONE) begin
      stg_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udma_spis_seq.sv
// Directed bench for udma_spis_seq: normal frames, queue full, overflow,
// underrun, unarmed seot, abort and asynchronous reset.
module tb_udma_spis_seq;

  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            cfg_abort = 1'b0;
  logic            seot = 1'b0;
  logic [7:0]      eng_rx_data = '0;
  logic            eng_rx_wr = 1'b0;
  logic            eng_tx_rd = 1'b0;
  logic [CNTW-1:0] cfgrxcnt, cfgdmcnt, cfgtxcnt;
  logic [7:0]      eng_tx_data;
  logic            busy, evt_done;
  logic [CNTW-1:0] st_rxbytes, st_txbytes;
  logic [3:0]      st_flags;

  int passed = 0;
  int total  = 0;

  udma_spis_seq_if #(.CNTW(CNTW)) bus ();

  udma_spis_seq #(.DESC_DEPTH(2), .CNTW(CNTW)) dut (
    .clk(clk), .resetn(resetn), .cfg_abort(cfg_abort), .bus(bus),
    .cfgrxcnt(cfgrxcnt), .cfgdmcnt(cfgdmcnt), .cfgtxcnt(cfgtxcnt),
    .seot(seot), .eng_rx_data(eng_rx_data), .eng_rx_wr(eng_rx_wr),
    .eng_tx_data(eng_tx_data), .eng_tx_rd(eng_tx_rd),
    .busy(busy), .evt_done(evt_done),
    .st_rxbytes(st_rxbytes), .st_txbytes(st_txbytes), .st_flags(st_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CNTW-1:0] r, input logic [CNTW-1:0] d, input logic [CNTW-1:0] t);
    bus.desc_valid = 1'b1;
    bus.desc_rxcnt = r;
    bus.desc_dmcnt = d;
    bus.desc_txcnt = t;
  endtask

  task automatic check_cfg(input string tag, input logic [CNTW-1:0] r, input logic [CNTW-1:0] d, input logic [CNTW-1:0] t);
    check({tag, "_cfg"}, {cfgrxcnt, cfgdmcnt[7:0], cfgtxcnt[7:0]}, {r, d[7:0], t[7:0]});
  endtask

  task automatic check_status(input string tag, input logic [CNTW-1:0] r, input logic [CNTW-1:0] t, input logic [3:0] f);
    check({tag, "_evt"},   32'(evt_done),   32'd1);
    check({tag, "_strx"},  32'(st_rxbytes), 32'(r));
    check({tag, "_sttx"},  32'(st_txbytes), 32'(t));
    check({tag, "_flags"}, 32'(st_flags),   32'(f));
  endtask

  initial begin
    bus.desc_valid = 1'b0;
    bus.desc_rxcnt = '0;
    bus.desc_dmcnt = '0;
    bus.desc_txcnt = '0;
    bus.rx_ready   = 1'b1;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = '0;

    // Reset values
    #12;
    check_cfg("rst", 0, 0, 0);
    check("rst_txdata",  32'(eng_tx_data), 32'hFF);
    check("rst_rxvalid", 32'(bus.rx_valid), 32'd0);
    check("rst_txready", 32'(bus.tx_ready), 32'd1);
    check("rst_dready",  32'(bus.desc_ready), 32'd1);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_evt",     32'(evt_done), 32'd0);
    check("rst_st",      {st_rxbytes, st_txbytes[11:0], st_flags}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Frame 1: {4,2,4}, 4 rx bytes and 4 tx bytes 5A..5D
    tick();
    push(4, 2, 4);
    tick();
    bus.desc_valid = 1'b0;
    tick();
    check("f1_busy", 32'(busy), 32'd1);
    check_cfg("f1_arm", 4, 2, 4);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h5A;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.tx_valid = (i < 3);
      bus.tx_data  = 8'h5B + 8'(i);
      eng_tx_rd    = 1'b1;
      eng_rx_wr    = 1'b1;
      eng_rx_data  = 8'hA0 + 8'(i);
      #1;
      check($sformatf("f1_txbyte%0d", i), 32'(eng_tx_data), 32'h5A + i);
      tick();
      check($sformatf("f1_rxbyte%0d", i), {23'd0, bus.rx_valid, bus.rx_data}, 32'h1A0 + i);
    end
    eng_tx_rd    = 1'b0;
    eng_rx_wr    = 1'b0;
    bus.tx_valid = 1'b0;
    tick();
    check("f1_rxdrain",  32'(bus.rx_valid), 32'd0);
    check("f1_txempty",  32'(eng_tx_data), 32'hFF);
    check_cfg("f1_hold", 4, 2, 4);
    seot = 1'b1;
    tick();
    seot = 1'b0;
    check("f1_done_busy", 32'(busy), 32'd1);
    check("f1_done_noevt", 32'(evt_done), 32'd0);
    tick();
    check_status("f1", 4, 4, 4'b0000);
    check("f1_idle", 32'(busy), 32'd0);
    check_cfg("f1_idle", 0, 0, 0);
    tick();
    check("f1_evt_once", 32'(evt_done), 32'd0);

    // Frames 2..4: queue fill, full reject, back-to-back retire
    push(1, 0, 8);
    tick();
    push(8, 0, 0);
    tick();
    check_cfg("q_d1", 1, 0, 8);
    check("q_ready1", 32'(bus.desc_ready), 32'd1);
    push(3, 0, 0);
    tick();
    check("q_full", 32'(bus.desc_ready), 32'd0);
    push(7, 7, 7);
    tick();
    bus.desc_valid = 1'b0;
    check("q_still_full", 32'(bus.desc_ready), 32'd0);
    eng_rx_wr   = 1'b1;
    eng_rx_data = 8'h77;
    tick();
    eng_rx_wr = 1'b0;
    check("d1_rx", {23'd0, bus.rx_valid, bus.rx_data}, 32'h177);
    seot = 1'b1;
    tick();
    seot = 1'b0;
    check_cfg("d1_done", 1, 0, 8);
    tick();
    check_status("d1", 1, 0, 4'b0000);
    check_cfg("d2_arm", 8, 0, 0);
    check("d2_ready", 32'(bus.desc_ready), 32'd1);
    seot = 1'b1;
    tick();
    seot = 1'b0;
    check_cfg("d2_done", 8, 0, 0);
    tick();
    check_status("d2", 0, 0, 4'b0100);
    check_cfg("d3_arm", 3, 0, 0);

    // Frame 4: rx overflow with rx_ready low
    bus.rx_ready = 1'b0;
    eng_rx_wr    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eng_rx_data = 8'h11 * 8'(i + 1);
      tick();
    end
    eng_rx_wr = 1'b0;
    check("ovf_data", {23'd0, bus.rx_valid, bus.rx_data}, 32'h133);
    bus.rx_ready = 1'b1;
    tick();
    check("ovf_drain", 32'(bus.rx_valid), 32'd0);
    seot = 1'b1;
    tick();
    seot = 1'b0;
    tick();
    check_status("ovf", 3, 0, 4'b0001);
    check("ovf_idle", 32'(busy), 32'd0);
    check_cfg("ovf_idle", 0, 0, 0);

    // Frame 5: tx underrun
    push(0, 0, 2);
    tick();
    bus.desc_valid = 1'b0;
    tick();
    check_cfg("udr_arm", 0, 0, 2);
    eng_tx_rd = 1'b1;
    #1;
    check("udr_ff0", 32'(eng_tx_data), 32'hFF);
    tick();
    check("udr_ff1", 32'(eng_tx_data), 32'hFF);
    tick();
    eng_tx_rd = 1'b0;
    seot = 1'b1;
    tick();
    seot = 1'b0;
    tick();
    check_status("udr", 0, 2, 4'b0010);

    // seot with nothing armed
    tick();
    seot = 1'b1;
    tick();
    seot = 1'b0;
    check("unarm_busy", 32'(busy), 32'd1);
    tick();
    check_status("unarm", 0, 0, 4'b1000);
    check("unarm_idle", 32'(busy), 32'd0);

    // Abort during ACTIVE with one descriptor queued; simultaneous push dropped
    push(2, 0, 0);
    tick();
    bus.desc_valid = 1'b0;
    tick();
    push(5, 5, 5);
    tick();
    bus.desc_valid = 1'b0;
    bus.rx_ready   = 1'b0;
    eng_rx_wr      = 1'b1;
    eng_rx_data    = 8'h99;
    tick();
    eng_rx_wr = 1'b0;
    check("ab_active_rx", 32'(bus.rx_valid), 32'd1);
    cfg_abort = 1'b1;
    push(6, 6, 6);
    tick();
    cfg_abort      = 1'b0;
    bus.desc_valid = 1'b0;
    check_status("ab", 1, 0, 4'b0100);
    check("ab_busy", 32'(busy), 32'd0);
    check_cfg("ab", 0, 0, 0);
    check("ab_rxclr", 32'(bus.rx_valid), 32'd0);
    check("ab_ready", 32'(bus.desc_ready), 32'd1);
    bus.rx_ready = 1'b1;
    tick();
    check("ab_evt_off", 32'(evt_done), 32'd0);
    check("ab_qempty", 32'(busy), 32'd0);
    tick();
    check_cfg("ab_after", 0, 0, 0);

    // Asynchronous reset mid-frame
    push(9, 9, 9);
    tick();
    bus.desc_valid = 1'b0;
    tick();
    check_cfg("ar_arm", 9, 9, 9);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h42;
    tick();
    bus.tx_valid = 1'b0;
    check("ar_staged", 32'(eng_tx_data), 32'h42);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check_cfg("ar", 0, 0, 0);
    check("ar_txdata", 32'(eng_tx_data), 32'hFF);
    check("ar_txready", 32'(bus.tx_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
